// File: rtl/uop_sequencer.sv
// Micro-op sequencer: accepts one instruction word and issues its (reg_load, select) micro-ops one per
// handshake, then reports the instruction byte length. Unknown opcodes are flagged as illegal.
module uop_sequencer #(
  parameter int OPE_W     = 32,
  parameter int SEL_W     = 4,
  parameter int MAX_STEPS = 4,
  parameter int LEN_W     = 4
) (
  input  logic                          clk2,
  input  logic                          reset_n,
  input  logic [OPE_W-1:0]              ope,
  input  logic                          ope_valid,
  output logic                          ope_ready,
  input  logic                          flush,
  output logic                          uop_valid,
  input  logic                          uop_ready,
  output logic [SEL_W-1:0]              reg_load,
  output logic [SEL_W-1:0]              select,
  output logic [$clog2(MAX_STEPS)-1:0]  uop_step,
  output logic                          uop_last,
  output logic                          len_valid,
  output logic [LEN_W-1:0]              num_of_ope,
  output logic                          illegal
);

  localparam int STEP_W = $clog2(MAX_STEPS);
  localparam int CNT_W  = STEP_W + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t              state_q, state_d;
  logic [7:0]          op_q, op_d;
  logic [CNT_W-1:0]    steps_q, steps_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                ready_d, vld_d, last_d, lenv_d, ill_d;
  logic [SEL_W-1:0]    rl_d, sel_d;
  logic [STEP_W-1:0]   step_d;
  logic [LEN_W-1:0]    num_d;
  logic [6:0]          info;
  logic [5:0]          code;
  logic [7:0]          opc;
  logic                unused_ope_bits;

  assign opc             = ope[OPE_W-1 -: 8];
  assign unused_ope_bits = ^ope[OPE_W-9:0];

  // {known, step count, byte length}
  function automatic logic [6:0] op_info(input logic [7:0] op);
    case (op)
      8'h55:   op_info = {1'b1, 3'd2, 3'd1};
      8'h89:   op_info = {1'b1, 3'd1, 3'd2};
      8'hb8:   op_info = {1'b1, 3'd1, 3'd5};
      8'h5d:   op_info = {1'b1, 3'd2, 3'd1};
      8'hc3:   op_info = {1'b1, 3'd2, 3'd1};
      8'he2:   op_info = {1'b1, 3'd3, 3'd5};
      8'h6a:   op_info = {1'b1, 3'd2, 3'd2};
      default: op_info = '0;
    endcase
  endfunction

  // {reg_load, select} for a given opcode and step; unused slots are 0
  function automatic logic [5:0] uop_code(input logic [7:0] op, input logic [STEP_W-1:0] s);
    uop_code = '0;
    case (op)
      8'h55: case (int'(s)) 0: uop_code = {3'd1, 3'd2}; 1: uop_code = {3'd1, 3'd1}; default: ; endcase
      8'h89: case (int'(s)) 0: uop_code = {3'd2, 3'd2}; default: ; endcase
      8'hb8: case (int'(s)) 0: uop_code = {3'd3, 3'd3}; default: ; endcase
      8'h5d: case (int'(s)) 0: uop_code = {3'd2, 3'd4}; 1: uop_code = {3'd2, 3'd2}; default: ; endcase
      8'hc3: case (int'(s)) 0: uop_code = {3'd4, 3'd4}; 1: uop_code = {3'd2, 3'd2}; default: ; endcase
      8'he2: case (int'(s))
               0: uop_code = {3'd1, 3'd2};
               1: uop_code = {3'd1, 3'd3};
               2: uop_code = {3'd4, 3'd2};
               default: ;
             endcase
      8'h6a: case (int'(s)) 0: uop_code = {3'd1, 3'd2}; 1: uop_code = {3'd1, 3'd4}; default: ; endcase
      default: uop_code = '0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] clamp_steps(input logic [2:0] n);
    if (int'(n) > MAX_STEPS) clamp_steps = CNT_W'(MAX_STEPS);
    else                     clamp_steps = CNT_W'(n);
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    steps_d = steps_q;
    len_d   = len_q;
    vld_d   = uop_valid;
    step_d  = uop_step;
    rl_d    = reg_load;
    sel_d   = select;
    lenv_d  = 1'b0;
    ill_d   = 1'b0;
    num_d   = num_of_ope;
    info    = op_info(opc);
    code    = '0;
    case (state_q)
      IDLE: begin
        if (!flush && ope_valid) begin
          if (info[6]) begin
            state_d = ISSUE;
            op_d    = opc;
            steps_d = clamp_steps(info[5:3]);
            len_d   = LEN_W'(info[2:0]);
            vld_d   = 1'b1;
            step_d  = '0;
            code    = uop_code(opc, '0);
            rl_d    = SEL_W'(code[5:3]);
            sel_d   = SEL_W'(code[2:0]);
            ill_d   = (int'(info[5:3]) > MAX_STEPS);
          end else begin
            ill_d  = 1'b1;
            lenv_d = 1'b1;
            num_d  = LEN_W'(1);
          end
        end
      end
      ISSUE: begin
        if (flush) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          step_d  = '0;
          rl_d    = '0;
          sel_d   = '0;
        end else if (uop_ready) begin
          if (uop_last) begin
            state_d = IDLE;
            vld_d   = 1'b0;
            step_d  = '0;
            rl_d    = '0;
            sel_d   = '0;
            lenv_d  = 1'b1;
            num_d   = len_q;
          end else begin
            step_d = uop_step + STEP_W'(1);
            code   = uop_code(op_q, step_d);
            rl_d   = SEL_W'(code[5:3]);
            sel_d  = SEL_W'(code[2:0]);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    last_d  = vld_d && ({1'b0, step_d} == (steps_d - CNT_W'(1)));
    ready_d = (state_d == IDLE);
  end

  // Registered state and outputs
  always_ff @(posedge clk2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      steps_q    <= '0;
      len_q      <= '0;
      ope_ready  <= 1'b1;
      uop_valid  <= 1'b0;
      uop_step   <= '0;
      uop_last   <= 1'b0;
      reg_load   <= '0;
      select     <= '0;
      len_valid  <= 1'b0;
      num_of_ope <= '0;
      illegal    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      steps_q    <= steps_d;
      len_q      <= len_d;
      ope_ready  <= ready_d;
      uop_valid  <= vld_d;
      uop_step   <= step_d;
      uop_last   <= last_d;
      reg_load   <= rl_d;
      select     <= sel_d;
      len_valid  <= lenv_d;
      num_of_ope <= num_d;
      illegal    <= ill_d;
    end
  end

endmodule
